// File: rtl/simmem_delay_releaser.sv
// Release-enable generator for the simulated-memory response path.
// Each accepted request waits in a delay slot while its counter runs down. When the counter
// expires, the slot turns into a per-ID release credit. release_en_o[id] is high while that
// ID holds at least one credit. Each response the bank reports as released uses up one credit.
module simmem_delay_releaser #(
    parameter int unsigned IDWidth    = 4,
    parameter int unsigned NumSlots   = 16,
    parameter int unsigned DelayWidth = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [IDWidth-1:0]               req_id_i,
    input  logic [DelayWidth-1:0]            req_delay_i,
    output logic [2**IDWidth-1:0]            release_en_o,
    input  logic                             rsp_released_i,
    input  logic [IDWidth-1:0]               rsp_released_id_i,
    output logic [$clog2(NumSlots+1)-1:0]    outstanding_o
);

    localparam int unsigned NumIds   = 2 ** IDWidth;
    localparam int unsigned CntWidth = $clog2(NumSlots + 1);
    localparam int unsigned SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    // Delay slot state
    logic [NumSlots-1:0]   slot_valid_q, slot_valid_d;
    logic [IDWidth-1:0]    slot_id_q    [NumSlots];
    logic [IDWidth-1:0]    slot_id_d    [NumSlots];
    logic [DelayWidth-1:0] slot_cnt_q   [NumSlots];
    logic [DelayWidth-1:0] slot_cnt_d   [NumSlots];

    // Per-ID release credits and the total occupancy (slots in use plus credits)
    logic [CntWidth-1:0]   credit_q     [NumIds];
    logic [CntWidth-1:0]   credit_d     [NumIds];
    logic [CntWidth-1:0]   outstanding_q, outstanding_d;

    logic                  free_found;
    logic [SlotIdxW-1:0]   free_idx;
    logic                  xfer_found;
    logic [SlotIdxW-1:0]   xfer_idx;
    logic [IDWidth-1:0]    xfer_id;
    logic                  accept;
    logic                  rel_ok;

    // Ready is derived from registered occupancy only and is forced low during reset
    assign req_ready_o   = !rst_i && (outstanding_q < CntWidth'(NumSlots));
    assign accept        = req_valid_i && req_ready_o && free_found;
    assign rel_ok        = rsp_released_i && (credit_q[rsp_released_id_i] != '0);
    assign xfer_id       = slot_id_q[xfer_idx];
    assign outstanding_o = outstanding_q;

    // Find the lowest-index free slot, using registered valid bits only
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!slot_valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SlotIdxW'(i);
            end
        end
    end

    // Find the lowest-index expired slot; only this slot moves into a credit this cycle
    always_comb begin
        xfer_found = 1'b0;
        xfer_idx   = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (slot_valid_q[i] && (slot_cnt_q[i] == '0) && !xfer_found) begin
                xfer_found = 1'b1;
                xfer_idx   = SlotIdxW'(i);
            end
        end
    end

    // Slot next state: count down, free the transferred slot, load the accepted request
    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int i = 0; i < NumSlots; i++) begin
            slot_id_d[i]  = slot_id_q[i];
            slot_cnt_d[i] = slot_cnt_q[i];
            if (slot_valid_q[i] && (slot_cnt_q[i] != '0)) begin
                slot_cnt_d[i] = slot_cnt_q[i] - 1'b1;
            end
        end
        if (xfer_found) begin
            slot_valid_d[xfer_idx] = 1'b0;
        end
        // free_idx comes from !slot_valid_q, so it never equals xfer_idx
        if (accept) begin
            slot_valid_d[free_idx] = 1'b1;
            slot_id_d[free_idx]    = req_id_i;
            slot_cnt_d[free_idx]   = req_delay_i;
        end
    end

    // Credit next state: a transfer adds one and a valid release removes one;
    // both on the same ID in the same cycle leave the count unchanged
    always_comb begin
        for (int j = 0; j < NumIds; j++) begin
            credit_d[j] = credit_q[j];
            if (xfer_found && (xfer_id == IDWidth'(j))) begin
                credit_d[j] = credit_d[j] + 1'b1;
            end
            if (rel_ok && (rsp_released_id_i == IDWidth'(j))) begin
                credit_d[j] = credit_d[j] - 1'b1;
            end
        end
    end

    // Occupancy next state: transfers move an entry from slot to credit without changing it
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({accept, rel_ok})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Release-enable decode from registered credits
    always_comb begin
        release_en_o = '0;
        for (int j = 0; j < NumIds; j++) begin
            release_en_o[j] = (credit_q[j] != '0);
        end
    end

    // State registers; reset drops all pending timings and credits immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid_q  <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                slot_id_q[i]  <= '0;
                slot_cnt_q[i] <= '0;
            end
            for (int j = 0; j < NumIds; j++) begin
                credit_q[j] <= '0;
            end
        end else begin
            slot_valid_q  <= slot_valid_d;
            outstanding_q <= outstanding_d;
            for (int i = 0; i < NumSlots; i++) begin
                slot_id_q[i]  <= slot_id_d[i];
                slot_cnt_q[i] <= slot_cnt_d[i];
            end
            for (int j = 0; j < NumIds; j++) begin
                credit_q[j] <= credit_d[j];
            end
        end
    end

`ifndef SYNTHESIS
    // Flag a release pulse for an ID that holds no credit; the pulse itself is ignored
    always_ff @(posedge clk_i) begin
        if (!rst_i && rsp_released_i && (credit_q[rsp_released_id_i] == '0)) begin
            $warning("simmem_delay_releaser: release for id %0d with no credit ignored",
                     rsp_released_id_i);
        end
    end
`endif

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Directed bench for simmem_delay_releaser: reset, single timing, transfer ordering,
// full stall, same-cycle transfer/release, spurious release and mid-countdown reset.
module tb_simmem_delay_releaser;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [7:0]  req_delay;
    logic [15:0] release_en;
    logic        rsp_released;
    logic [3:0]  rsp_released_id;
    logic [4:0]  outstanding;

    int checks   = 0;
    int failures = 0;

    simmem_delay_releaser #(
        .IDWidth    (4),
        .NumSlots   (16),
        .DelayWidth (8)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_id_i          (req_id),
        .req_delay_i       (req_delay),
        .release_en_o      (release_en),
        .rsp_released_i    (rsp_released),
        .rsp_released_id_i (rsp_released_id),
        .outstanding_o     (outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set before the call apply at that edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] id, input logic [7:0] d);
        req_valid = 1'b1;
        req_id    = id;
        req_delay = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic rel(input logic [3:0] id);
        rsp_released    = 1'b1;
        rsp_released_id = id;
        tick();
        rsp_released    = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_id          = '0;
        req_delay       = '0;
        rsp_released    = 1'b0;
        rsp_released_id = '0;

        // 1 Reset
        #3;
        chk("rst_en", 32'(release_en), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_outst", 32'(outstanding), 32'h0);
        tick();
        chk("rst_ready_edge", 32'(req_ready), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        // 2 Single: id 3 delay 5 -> credit at the sixth edge after accept
        send(4'd3, 8'd5);
        chk("single_outst1", 32'(outstanding), 32'h1);
        chk("single_en_e0", 32'(release_en), 32'h0);
        repeat (5) tick();
        chk("single_en_e5", 32'(release_en), 32'h0);
        tick();
        chk("single_en_e6", 32'(release_en), 32'h0008);
        chk("single_outst_e6", 32'(outstanding), 32'h1);
        rel(4'd3);
        chk("single_rel_en", 32'(release_en), 32'h0);
        chk("single_rel_outst", 32'(outstanding), 32'h0);

        // 3 Back-to-back zero delays
        send(4'd1, 8'd0);
        send(4'd2, 8'd0);
        chk("b2b_en_a", 32'(release_en), 32'h0002);
        chk("b2b_outst", 32'(outstanding), 32'h2);
        tick();
        chk("b2b_en_b", 32'(release_en), 32'h0006);
        rel(4'd1);
        rel(4'd2);
        chk("b2b_clear", 32'(outstanding), 32'h0);
        // ids 4,5 expire together; the lower slot (id 4) transfers first
        send(4'd4, 8'd2);
        send(4'd5, 8'd1);
        chk("cont_en_f1", 32'(release_en), 32'h0);
        tick();
        chk("cont_en_f2", 32'(release_en), 32'h0);
        tick();
        chk("cont_en_f3", 32'(release_en), 32'h0010);
        tick();
        chk("cont_en_f4", 32'(release_en), 32'h0030);
        chk("cont_outst", 32'(outstanding), 32'h2);
        rel(4'd4);
        rel(4'd5);
        chk("cont_clear", 32'(outstanding), 32'h0);

        // 4 Full: sixteen requests with valid held high
        req_valid = 1'b1;
        req_delay = 8'd1;
        for (int i = 0; i < 16; i++) begin
            req_id = 4'(i);
            tick();
        end
        chk("full_outst", 32'(outstanding), 32'd16);
        chk("full_ready", 32'(req_ready), 32'h0);
        req_id = 4'd0;
        repeat (3) tick();
        chk("full_stall_outst", 32'(outstanding), 32'd16);
        req_valid = 1'b0;
        repeat (20) tick();
        chk("full_en_all", 32'(release_en), 32'hFFFF);
        chk("full_ready_hold", 32'(req_ready), 32'h0);
        rel(4'd0);
        chk("full_rel_ready", 32'(req_ready), 32'h1);
        chk("full_rel_outst", 32'(outstanding), 32'd15);
        chk("full_rel_en", 32'(release_en), 32'hFFFE);
        for (int i = 1; i < 16; i++) begin
            rel(4'(i));
        end
        chk("full_drain_outst", 32'(outstanding), 32'h0);
        chk("full_drain_en", 32'(release_en), 32'h0);

        // 5 Same-cycle transfer and release on id 7
        send(4'd7, 8'd0);
        tick();
        chk("tr_en_first", 32'(release_en), 32'h0080);
        send(4'd7, 8'd0);
        chk("tr_outst_2", 32'(outstanding), 32'h2);
        rel(4'd7);
        chk("tr_en_kept", 32'(release_en), 32'h0080);
        chk("tr_outst_1", 32'(outstanding), 32'h1);
        // accept id 8 and release id 7 on the same edge
        req_valid       = 1'b1;
        req_id          = 4'd8;
        req_delay       = 8'd3;
        rsp_released    = 1'b1;
        rsp_released_id = 4'd7;
        tick();
        req_valid       = 1'b0;
        rsp_released    = 1'b0;
        chk("acc_rel_outst", 32'(outstanding), 32'h1);
        chk("acc_rel_en", 32'(release_en), 32'h0);
        repeat (3) tick();
        chk("acc_rel_en_g7", 32'(release_en), 32'h0);
        tick();
        chk("acc_rel_en_g8", 32'(release_en), 32'h0100);
        rel(4'd8);
        chk("acc_rel_clear", 32'(outstanding), 32'h0);

        // 6 Spurious release is ignored
        send(4'd2, 8'd0);
        tick();
        chk("spur_base_en", 32'(release_en), 32'h0004);
        rel(4'd9);
        chk("spur_en", 32'(release_en), 32'h0004);
        chk("spur_outst", 32'(outstanding), 32'h1);
        rel(4'd2);
        chk("spur_clear", 32'(outstanding), 32'h0);

        // Reset mid-countdown drops the pending timing
        send(4'd10, 8'd5);
        tick();
        tick();
        chk("mid_outst_pre", 32'(outstanding), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_en", 32'(release_en), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_outst", 32'(outstanding), 32'h0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_after_en", 32'(release_en), 32'h0);
        chk("mid_after_outst", 32'(outstanding), 32'h0);
        chk("mid_after_ready", 32'(req_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
